mfp_bot_irq_bridge: RTL and testbench
=====================================

// Module: mfp_bot_irq_bridge
// PURPOSE
//  Downstream consumer of the Rojobot update handshake. When the latched update flag
//  (IO_BotUpdt_Sync) is set, snapshots the bot registers and raises an interrupt to
//  the MIPS core. It then exposes the snapshot on a simple memory-mapped read port,
//  and returns IO_INT_ACK when software writes the ACK register. Sits between the
//  update/ack flag register and the MFP MMIO bus.
// PARAMETERS
//  ACK_CYCLES  2   cycles IO_INT_ACK held high per ack (1..15)
//  OVR_W       16  width of overrun counter (saturating)
// PORTS
//  clk1_in          in   1   50 MHz system clock; only clock
//  reset            in   1   synchronous, active-high reset
//  IO_BotUpdt       in   1   raw update pulse from Rojobot (overrun detect only)
//  IO_BotUpdt_Sync  in   1   latched update flag from handshake stage
//  IO_INT_ACK       out  1   clears the handshake flag
//  LocX_reg         in   8   bot X location
//  LocY_reg         in   8   bot Y location
//  Sensors_reg      in   8   bot sensor bits
//  BotInfo_reg      in   8   bot heading/movement
//  IO_BotCtrl       out  8   motor control byte to Rojobot
//  bot_irq          out  1   level interrupt to MIPS core
//  bus_addr         in   3   word index: 0 BOTINFO, 1 STATUS, 2 ACK, 3 CTRL, 4 IRQEN
//  bus_we           in   1   write strobe, one cycle
//  bus_re           in   1   read strobe, one cycle
//  bus_wdata        in   32  write data
//  bus_rdata        out  32  read data, valid cycle after bus_re
// BEHAVIOUR
//  Reset: every output = 0, snapshot = 0, ovr_cnt = 0, state = IDLE, irq_en = 1.
//  FSM: IDLE -> PEND when IO_BotUpdt_Sync=1. Snapshot {LocX,LocY,Sensors,BotInfo}
//    is registered that same edge, and bot_irq rises next cycle.
//  PEND: bot_irq=1. A bus write to ACK (any data) -> ACK; bot_irq drops next cycle.
//  ACK: IO_INT_ACK=1 for exactly ACK_CYCLES cycles -> DRAIN.
//  DRAIN: IO_INT_ACK=0; wait for IO_BotUpdt_Sync=0, then -> IDLE. This blocks
//    re-capture of a stale flag.
//  Overrun: an IO_BotUpdt=1 cycle seen in PEND/ACK/DRAIN increments ovr_cnt. The
//    counter saturates at all-ones. Snapshot is NOT overwritten.
//  ACK write outside PEND: ignored, no IO_INT_ACK.
//  Simultaneous bus_we and bus_re: both serviced. A read of STATUS in the same
//    cycle as an ACK write returns the pre-write state.
//  Reads (1-cycle latency, registered):
//    BOTINFO = {LocX,LocY,Sensors,BotInfo} snapshot
//    STATUS  = {ovr_cnt zero-ext to 16, 13'b0, state[1:0], pending}
//    CTRL    = {24'b0, IO_BotCtrl}
//    undefined addr = 0
//  Reading STATUS clears ovr_cnt (read-to-clear). A simultaneous increment wins:
//    the counter becomes 1.
//  Writes: CTRL loads IO_BotCtrl <= bus_wdata[7:0] next cycle. Other addrs ignored.
//  reset mid-operation: returns to IDLE within one edge and drops IO_INT_ACK
//    immediately. The handshake flag stays set and is recaptured after reset.
// CONFIGURATION
//  BOT_IRQ_MASK_EN defined: addr 4 is RW irq_en (bit0); bot_irq = pending & irq_en.
//    The FSM and capture are unaffected by the mask.
//  Not defined: addr 4 reads 0 and writes are ignored; bot_irq = pending.
// STRUCTURE
//  Shared package mfp_bot_pkg: state encoding (IDLE=0, PEND=1, ACK=2, DRAIN=3),
//    register word indices, BOTINFO field offsets.
//  One sub-module: mfp_bot_regfile (bus decode, read mux, CTRL/IRQEN regs,
//    ovr_cnt). The FSM stays in the top.
// TESTING
//  1 Sync=1 with Loc=0x12/0x34, Sens=0x56, Info=0x78 -> bot_irq=1 next cycle;
//    BOTINFO reads 0x12345678.
//  2 ACK write in PEND, ACK_CYCLES=2 -> IO_INT_ACK high exactly 2 cycles; IDLE
//    after Sync falls.
//  3 Three IO_BotUpdt pulses while PEND -> STATUS[31:16]=3; second read returns 0;
//    snapshot unchanged.
//  4 ACK write in IDLE -> IO_INT_ACK stays 0; state stays 0.
//  5 reset asserted during ACK -> IO_INT_ACK=0 next edge; all outputs 0; Sync still
//    1 -> PEND after reset.
//  6 BOT_IRQ_MASK_EN: write IRQEN=0, then Sync=1 -> state=PEND, bot_irq=0; write
//    IRQEN=1 -> bot_irq=1.

Source files
------------

// File: rtl/mfp_bot_pkg.sv
// mfp_bot_pkg: shared definitions for the Rojobot interrupt bridge
// Contents: FSM state encoding, MMIO word indices, BOTINFO field offsets,
// and a helper that packs the four bot registers into the BOTINFO word.
package mfp_bot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } bot_state_t;

    localparam logic [2:0] REG_BOTINFO = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_ACK     = 3'd2;
    localparam logic [2:0] REG_CTRL    = 3'd3;
    localparam logic [2:0] REG_IRQEN   = 3'd4;

    localparam int LOCX_OFS = 24;
    localparam int LOCY_OFS = 16;
    localparam int SENS_OFS = 8;
    localparam int INFO_OFS = 0;

    function automatic logic [31:0] pack_botinfo(
        input logic [7:0] loc_x,
        input logic [7:0] loc_y,
        input logic [7:0] sensors,
        input logic [7:0] bot_info
    );
        logic [31:0] w;
        w = '0;
        w[LOCX_OFS +: 8] = loc_x;
        w[LOCY_OFS +: 8] = loc_y;
        w[SENS_OFS +: 8] = sensors;
        w[INFO_OFS +: 8] = bot_info;
        return w;
    endfunction

endpackage

// File: rtl/mfp_bot_regfile.sv
// mfp_bot_regfile: MMIO decode, registered read mux, CTRL/IRQEN registers, overrun counter
// Ports:
//   clk1_in, reset        clock, synchronous active-high reset
//   bus_addr/we/re/wdata  MMIO request; bus_rdata is registered (valid the cycle after bus_re)
//   snapshot              captured BOTINFO word from the FSM
//   state, pending        FSM status shown in the STATUS word
//   ovr_inc               one overrun event this cycle
//   ack_wr                decoded write to the ACK word
//   irq_en                interrupt enable (constant 1 unless BOT_IRQ_MASK_EN is defined)
//   IO_BotCtrl            motor control byte
// Macro BOT_IRQ_MASK_EN: makes word 4 a read/write irq_en bit.
module mfp_bot_regfile
    import mfp_bot_pkg::*;
#(
    parameter int OVR_W = 16
) (
    input  logic        clk1_in,
    input  logic        reset,
    input  logic [2:0]  bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic [31:0] snapshot,
    input  bot_state_t  state,
    input  logic        pending,
    input  logic        ovr_inc,
    output logic        ack_wr,
    output logic        irq_en,
    output logic [7:0]  IO_BotCtrl
);

    logic [OVR_W-1:0] ovr_cnt;
    logic [31:0]      status_word;
    logic [31:0]      irqen_word;
    logic [31:0]      rd_mux;
    logic             status_rd;
    logic             unused_wdata;

    assign ack_wr       = bus_we && bus_addr == REG_ACK;
    assign status_rd    = bus_re && bus_addr == REG_STATUS;
    assign status_word  = {16'(ovr_cnt), 13'b0, state, pending};
    assign unused_wdata = ^bus_wdata[31:8];

`ifdef BOT_IRQ_MASK_EN
    logic irq_en_q;
    always_ff @(posedge clk1_in) begin
        if (reset)
            irq_en_q <= 1'b1;
        else if (bus_we && bus_addr == REG_IRQEN)
            irq_en_q <= bus_wdata[0];
    end
    assign irq_en     = irq_en_q;
    assign irqen_word = {31'b0, irq_en_q};
`else
    assign irq_en     = 1'b1;
    assign irqen_word = '0;
`endif

    always_comb begin
        rd_mux = bus_addr == REG_BOTINFO ? snapshot :
                 bus_addr == REG_STATUS  ? status_word :
                 bus_addr == REG_CTRL    ? {24'b0, IO_BotCtrl} :
                 bus_addr == REG_IRQEN   ? irqen_word : '0;
    end

    // Read-to-clear of STATUS loses to a same-cycle overrun, leaving the count at 1.
    always_ff @(posedge clk1_in) begin
        if (reset) begin
            ovr_cnt    <= '0;
            IO_BotCtrl <= '0;
            bus_rdata  <= '0;
        end else begin
            if (ovr_inc)
                ovr_cnt <= status_rd ? OVR_W'(1) : (&ovr_cnt ? ovr_cnt : ovr_cnt + 1'b1);
            else if (status_rd)
                ovr_cnt <= '0;
            if (bus_we && bus_addr == REG_CTRL)
                IO_BotCtrl <= bus_wdata[7:0];
            if (bus_re)
                bus_rdata <= rd_mux;
        end
    end

endmodule

// File: rtl/mfp_bot_irq_bridge.sv
// mfp_bot_irq_bridge: snapshots Rojobot registers on an update flag and interrupts the MIPS core
// Ports:
//   clk1_in, reset           clock, synchronous active-high reset
//   IO_BotUpdt               raw update pulse, used only to count overruns
//   IO_BotUpdt_Sync          latched update flag from the handshake stage
//   IO_INT_ACK               held high ACK_CYCLES cycles to clear that flag
//   LocX/LocY/Sensors/BotInfo_reg  bot registers captured into the snapshot
//   IO_BotCtrl               motor control byte (CTRL word)
//   bot_irq                  level interrupt
//   bus_*                    MMIO port: 0 BOTINFO, 1 STATUS, 2 ACK, 3 CTRL, 4 IRQEN
// Macro BOT_IRQ_MASK_EN: bot_irq is gated by the software irq_en bit.
module mfp_bot_irq_bridge
    import mfp_bot_pkg::*;
#(
    parameter int ACK_CYCLES = 2,
    parameter int OVR_W      = 16
) (
    input  logic        clk1_in,
    input  logic        reset,
    input  logic        IO_BotUpdt,
    input  logic        IO_BotUpdt_Sync,
    output logic        IO_INT_ACK,
    input  logic [7:0]  LocX_reg,
    input  logic [7:0]  LocY_reg,
    input  logic [7:0]  Sensors_reg,
    input  logic [7:0]  BotInfo_reg,
    output logic [7:0]  IO_BotCtrl,
    output logic        bot_irq,
    input  logic [2:0]  bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata
);

    bot_state_t  state;
    logic        pending;
    logic [3:0]  ack_cnt;
    logic [31:0] snapshot;
    logic        ack_wr;
    logic        irq_en;

    mfp_bot_regfile #(.OVR_W(OVR_W)) u_regfile (
        .clk1_in    (clk1_in),
        .reset      (reset),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .snapshot   (snapshot),
        .state      (state),
        .pending    (pending),
        .ovr_inc    (IO_BotUpdt && state != ST_IDLE),
        .ack_wr     (ack_wr),
        .irq_en     (irq_en),
        .IO_BotCtrl (IO_BotCtrl)
    );

    assign bot_irq = pending & irq_en;

    // DRAIN waits for the handshake flag to fall so a stale flag is not recaptured.
    always_ff @(posedge clk1_in) begin
        if (reset) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            IO_INT_ACK <= 1'b0;
            ack_cnt    <= '0;
            snapshot   <= '0;
        end else begin
            case (state)
                ST_IDLE:
                    if (IO_BotUpdt_Sync) begin
                        state    <= ST_PEND;
                        pending  <= 1'b1;
                        snapshot <= pack_botinfo(LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg);
                    end
                ST_PEND:
                    if (ack_wr) begin
                        state      <= ST_ACK;
                        pending    <= 1'b0;
                        IO_INT_ACK <= 1'b1;
                        ack_cnt    <= 4'(ACK_CYCLES - 1);
                    end
                ST_ACK:
                    if (ack_cnt == '0) begin
                        state      <= ST_DRAIN;
                        IO_INT_ACK <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt - 1'b1;
                    end
                ST_DRAIN:
                    if (!IO_BotUpdt_Sync)
                        state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_bot_irq_bridge.sv
// tb_mfp_bot_irq_bridge: scoreboard bench for the Rojobot interrupt bridge
module tb_mfp_bot_irq_bridge;

    logic        clk1_in = 1'b0;
    logic        reset;
    logic        IO_BotUpdt;
    logic        IO_BotUpdt_Sync;
    logic        IO_INT_ACK;
    logic [7:0]  LocX_reg;
    logic [7:0]  LocY_reg;
    logic [7:0]  Sensors_reg;
    logic [7:0]  BotInfo_reg;
    logic [7:0]  IO_BotCtrl;
    logic        bot_irq;
    logic [2:0]  bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        re_q = 1'b0;

    mfp_bot_irq_bridge #(.ACK_CYCLES(2), .OVR_W(16)) dut (
        .clk1_in         (clk1_in),
        .reset           (reset),
        .IO_BotUpdt      (IO_BotUpdt),
        .IO_BotUpdt_Sync (IO_BotUpdt_Sync),
        .IO_INT_ACK      (IO_INT_ACK),
        .LocX_reg        (LocX_reg),
        .LocY_reg        (LocY_reg),
        .Sensors_reg     (Sensors_reg),
        .BotInfo_reg     (BotInfo_reg),
        .IO_BotCtrl      (IO_BotCtrl),
        .bot_irq         (bot_irq),
        .bus_addr        (bus_addr),
        .bus_we          (bus_we),
        .bus_re          (bus_re),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (bus_rdata)
    );

    always #10 clk1_in = ~clk1_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk1_in);
    endtask

    task automatic bus_op(input logic we, input logic re, input logic [2:0] a,
                          input logic [31:0] wd, input logic [31:0] exp, input string tag);
        bus_we    = we;
        bus_re    = re;
        bus_addr  = a;
        bus_wdata = wd;
        if (re) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clk1_in);
        bus_we = 1'b0;
        bus_re = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus_op(1'b0, 1'b1, a, '0, exp, tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_op(1'b1, 1'b0, a, d, '0, "");
    endtask

    always @(posedge clk1_in) re_q <= bus_re;

    always @(negedge clk1_in) begin
        if (re_q) begin
            if (exp_q.size() == 0)
                chk("sb_underflow", 32'd1, 32'd0);
            else
                chk(tag_q.pop_front(), bus_rdata, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        IO_BotUpdt = 1'b0;
        IO_BotUpdt_Sync = 1'b0;
        {LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg} = '0;
        bus_addr = '0;
        bus_we = 1'b0;
        bus_re = 1'b0;
        bus_wdata = '0;
        step(2);
        reset = 1'b0;
        chk("rst_irq", 32'(bot_irq), 0);
        chk("rst_ack", 32'(IO_INT_ACK), 0);
        chk("rst_ctrl", 32'(IO_BotCtrl), 0);
        chk("rst_rdata", bus_rdata, 0);
        rd(3'd1, 32'h0, "rst_status");

        {LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg} = 32'h12345678;
        IO_BotUpdt_Sync = 1'b1;
        chk("irq_before_edge", 32'(bot_irq), 0);
        step(1);
        chk("irq_rise", 32'(bot_irq), 1);
        {LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg} = 32'h9ABCDEF0;
        rd(3'd0, 32'h12345678, "botinfo");
        rd(3'd1, 32'h00000003, "status_pend");

        repeat (3) begin
            IO_BotUpdt = 1'b1;
            step(1);
            IO_BotUpdt = 1'b0;
            step(1);
        end
        rd(3'd1, 32'h00030003, "ovr_three");
        rd(3'd1, 32'h00000003, "ovr_cleared");
        IO_BotUpdt = 1'b1;
        step(1);
        rd(3'd1, 32'h00010003, "ovr_rd_with_inc");
        IO_BotUpdt = 1'b0;
        rd(3'd1, 32'h00010003, "ovr_inc_wins");
        rd(3'd1, 32'h00000003, "ovr_zero");
        rd(3'd0, 32'h12345678, "snap_held");

        wr(3'd3, 32'hFFFF_FFA5);
        chk("ctrl_out", 32'(IO_BotCtrl), 32'hA5);
        rd(3'd3, 32'h000000A5, "ctrl_rd");
        bus_op(1'b1, 1'b1, 3'd3, 32'h3C, 32'h000000A5, "ctrl_rd_prewrite");
        chk("ctrl_new", 32'(IO_BotCtrl), 32'h3C);
        rd(3'd5, 32'h0, "undef5");
        rd(3'd7, 32'h0, "undef7");
`ifndef BOT_IRQ_MASK_EN
        wr(3'd4, 32'h0);
        rd(3'd4, 32'h0, "irqen_absent");
        chk("irq_unmasked", 32'(bot_irq), 1);
`endif

        wr(3'd2, 32'hDEAD_BEEF);
        chk("ack_c1", 32'(IO_INT_ACK), 1);
        chk("irq_drop", 32'(bot_irq), 0);
        step(1);
        chk("ack_c2", 32'(IO_INT_ACK), 1);
        step(1);
        chk("ack_end", 32'(IO_INT_ACK), 0);
        rd(3'd1, 32'h00000006, "status_drain");
        rd(3'd1, 32'h00000006, "drain_hold");
        IO_BotUpdt_Sync = 1'b0;
        step(1);
        rd(3'd1, 32'h0, "status_idle");

        wr(3'd2, 32'h0);
        chk("idle_ack0", 32'(IO_INT_ACK), 0);
        step(1);
        chk("idle_ack1", 32'(IO_INT_ACK), 0);
        rd(3'd1, 32'h0, "idle_state");

        {LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg} = 32'hAABBCCDD;
        IO_BotUpdt_Sync = 1'b1;
        step(1);
        chk("irq_again", 32'(bot_irq), 1);
        rd(3'd0, 32'hAABBCCDD, "botinfo2");
        wr(3'd2, 32'h1);
        chk("ack_pre_rst", 32'(IO_INT_ACK), 1);
        reset = 1'b1;
        step(1);
        chk("rst_mid_ack", 32'(IO_INT_ACK), 0);
        chk("rst_mid_irq", 32'(bot_irq), 0);
        chk("rst_mid_ctrl", 32'(IO_BotCtrl), 0);
        chk("rst_mid_rdata", bus_rdata, 0);
        reset = 1'b0;
        step(1);
        chk("recapture_irq", 32'(bot_irq), 1);
        rd(3'd0, 32'hAABBCCDD, "recapture_snap");
        rd(3'd1, 32'h00000003, "recapture_status");

        wr(3'd2, 32'h0);
        step(2);
        IO_BotUpdt_Sync = 1'b0;
        step(1);
`ifdef BOT_IRQ_MASK_EN
        rd(3'd4, 32'h1, "irqen_rst");
        wr(3'd4, 32'h0);
        IO_BotUpdt_Sync = 1'b1;
        step(1);
        chk("masked_irq", 32'(bot_irq), 0);
        rd(3'd1, 32'h00000003, "masked_pend");
        wr(3'd4, 32'h1);
        chk("unmasked_irq", 32'(bot_irq), 1);
        rd(3'd4, 32'h1, "irqen_rd");
`endif
        step(2);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
